hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter REG_AW, default 5, register-address width.
REQ-002 Parameter CNT_W, default 16, stall-counter width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 id_valid  in  1  ID stage holds a real instruction.
REQ-006 id_rs, id_rt  in  REG_AW each  ID source register addresses.
REQ-007 id_use_rs, id_use_rt  in  1 each  ID instruction actually reads rs / rt.
REQ-008 id_wr  in  1  ID instruction writes the register file.
REQ-009 id_wr_reg  in  REG_AW  ID destination register (rt or rd, already muxed).
REQ-010 id_load  in  1  ID instruction is a load.
REQ-011 br_taken  in  1  branch in MEM stage resolved taken this cycle.
REQ-012 stall  out  1  hold PC and IF/ID; ID/EX loads a bubble.
REQ-013 flush  out  1  clear IF/ID, ID/EX and the EX/MEM input.
REQ-014 fwd_a_sel, fwd_b_sel  out  2 each  EX operand source: 0 regfile, 1 EX/MEM result, 2 MEM/WB write data, 3 unused.
REQ-015 stall_cnt  out  CNT_W  saturating count of stall cycles.

Function
REQ-016 Block keeps a shadow of EX, MEM, WB stages; each entry: valid, wr, wr_reg, load, rs, rt, use_rs, use_rt.
REQ-017 Every cycle: WB <= MEM, MEM <= EX, EX <= ID fields if id_valid and not stall and not flush, else a bubble (valid=0).
REQ-018 flush = br_taken, combinational, same cycle; on flush, MEM shadow <= bubble and EX shadow <= bubble; WB <= MEM (branch itself retires).
REQ-019 flush has priority over stall: stall is forced 0 while br_taken=1.
REQ-020 A writer matches a source only if writer valid, wr=1, wr_reg != 0, wr_reg equals the source address, and the source use bit is 1.
REQ-021 Register 0 never causes a stall or forward.
REQ-022 Load-use (forwarding mode): stall=1 when EX shadow is a load matching id_rs or id_rt; exactly one stall cycle per load-use pair.
REQ-023 fwd_a_sel for EX shadow rs: 1 if MEM matches; else 2 if WB matches; else 0. Same rule for fwd_b_sel with rt. MEM has priority over WB.
REQ-024 fwd selects are combinational from shadow registers only (no input-to-output path); 0 when EX shadow is a bubble.
REQ-025 WB-to-ID distance needs no action: register file writes on the falling edge.
REQ-026 stall_cnt increments by 1 on each cycle with stall=1; holds at 2^CNT_W-1 (no wrap).
REQ-027 id_valid=0 never stalls, regardless of other ID fields.

Reset
REQ-028 rst_n=0 immediately clears all shadow valid bits and stall_cnt to 0; stall=0, flush=br_taken, fwd_a_sel=fwd_b_sel=0.
REQ-029 Reset mid-stall aborts it; first post-reset cycle evaluates hazards on empty shadow.

Configuration
REQ-030 Macro HAZARD_CTRL_FWD_EN defined: forwarding per REQ-022..REQ-024.
REQ-031 HAZARD_CTRL_FWD_EN undefined: fwd_a_sel=fwd_b_sel=0 always; stall=1 while any ID source matches EX or MEM shadow writer (load or not); one-cycle flush rule unchanged.

Verification
REQ-032 FWD_EN: add r3 in ID then sub using r3 next cycle -> stall stays 0, fwd_a_sel=1 when sub in EX.
REQ-033 FWD_EN: lw r5 then add r6,r5,r7 -> stall=1 one cycle, bubble in EX, then fwd_a_sel=2 when add in EX; stall_cnt 0->1.
REQ-034 Writer to r0 then reader of r0 -> stall=0, fwd selects 0 in both modes.
REQ-035 br_taken=1 while load-use stall pending -> flush=1, stall=0, EX and MEM shadows empty next cycle, fwd selects 0.
REQ-036 No FWD_EN: add r3 then reader of r3 -> stall=1 for exactly 2 cycles, fwd selects 0; stall_cnt 0->2.
REQ-037 CNT_W=2, hold continuous load-use stalls for 5 cycles -> stall_cnt reads 3 and stays; rst_n low mid-sequence -> counter 0, stall 0 asynchronously.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard detection (stall/flush/forward select) with EX/MEM/WB shadow; HAZARD_CTRL_FWD_EN enables forwarding
module hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_wr,
  input  logic [REG_AW-1:0] id_wr_reg,
  input  logic              id_load,
  input  logic              br_taken,
  output logic              stall,
  output logic              flush,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [CNT_W-1:0]  stall_cnt
);
  typedef struct packed {
    logic              valid;
    logic              wr;
    logic [REG_AW-1:0] wr_reg;
    logic              load;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              use_rs;
    logic              use_rt;
  } stage_t;
  stage_t ex, mem, wb, id_s;
  logic rs_u, rt_u;
  logic unused;
  function automatic logic hit(input stage_t w, input logic [REG_AW-1:0] a, input logic u);
    return w.valid && w.wr && (w.wr_reg != '0) && (w.wr_reg == a) && u;
  endfunction
  assign flush = br_taken;
  assign rs_u = id_valid & id_use_rs;
  assign rt_u = id_valid & id_use_rt;
  assign unused = ^{ex, mem, wb};
  // Pack the ID fields so they can be shifted into the EX shadow as one entry
  always_comb begin
    id_s = '{valid: id_valid, wr: id_wr, wr_reg: id_wr_reg, load: id_load,
             rs: id_rs, rt: id_rt, use_rs: id_use_rs, use_rt: id_use_rt};
  end
`ifdef HAZARD_CTRL_FWD_EN
  // Only a load in EX forces a stall; everything else is forwarded, MEM before WB
  always_comb begin
    stall = !br_taken && ex.load && (hit(ex, id_rs, rs_u) || hit(ex, id_rt, rt_u));
    fwd_a_sel = !ex.valid ? 2'd0 : hit(mem, ex.rs, ex.use_rs) ? 2'd1 : hit(wb, ex.rs, ex.use_rs) ? 2'd2 : 2'd0;
    fwd_b_sel = !ex.valid ? 2'd0 : hit(mem, ex.rt, ex.use_rt) ? 2'd1 : hit(wb, ex.rt, ex.use_rt) ? 2'd2 : 2'd0;
  end
`else
  // Without forwarding, wait until any pending writer has left EX and MEM
  always_comb begin
    stall = !br_taken && (hit(ex, id_rs, rs_u) || hit(ex, id_rt, rt_u) ||
                          hit(mem, id_rs, rs_u) || hit(mem, id_rt, rt_u));
    fwd_a_sel = 2'd0;
    fwd_b_sel = 2'd0;
  end
`endif
  // Advance the shadow pipeline, inserting bubbles on stall/flush, and count stall cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex        <= '0;
      mem       <= '0;
      wb        <= '0;
      stall_cnt <= '0;
    end else begin
      wb  <= mem;
      mem <= flush ? '0 : ex;
      ex  <= (id_valid && !stall && !flush) ? id_s : '0;
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl (expectations follow HAZARD_CTRL_FWD_EN)
module tb_hazard_ctrl;
  localparam int AW = 5;
  localparam int CW = 2;
`ifdef HAZARD_CTRL_FWD_EN
  localparam bit F = 1'b1;
`else
  localparam bit F = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid, id_use_rs, id_use_rt, id_wr, id_load, br_taken;
  logic [AW-1:0] id_rs, id_rt, id_wr_reg;
  logic stall, flush;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [CW-1:0] stall_cnt;
  int n_run = 0;
  int n_fail = 0;
  hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr(id_wr), .id_wr_reg(id_wr_reg),
    .id_load(id_load), .br_taken(br_taken), .stall(stall), .flush(flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic id(input logic v, input int rs, input int rt, input logic urs, input logic urt,
                    input logic wr, input int wreg, input logic ld);
    id_valid = v; id_rs = rs[AW-1:0]; id_rt = rt[AW-1:0]; id_use_rs = urs; id_use_rt = urt;
    id_wr = wr; id_wr_reg = wreg[AW-1:0]; id_load = ld;
  endtask
  task automatic nop();
    id(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic smp();
    @(negedge clk);
  endtask
  task automatic rst_seq();
    rst_n = 1'b0; nop(); br_taken = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int k;
    nop(); br_taken = 1'b1;
    #2;
    chk("rst_stall", stall, 0);
    chk("rst_flush_follows_br", flush, 1);
    chk("rst_fa", fwd_a_sel, 0);
    chk("rst_fb", fwd_b_sel, 0);
    chk("rst_cnt", stall_cnt, 0);
    br_taken = 1'b0; #1;
    chk("rst_flush_low", flush, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    // add r3,r1,r2 then sub r4,r3,r1
    id(1'b1, 1, 2, 1'b1, 1'b1, 1'b1, 3, 1'b0); smp();
    chk("A1_stall", stall, 0);
    tick();
    id(1'b1, 3, 1, 1'b1, 1'b1, 1'b1, 4, 1'b0); smp();
    chk("A2_stall", stall, F ? 0 : 1);
    chk("A2_fa", fwd_a_sel, 0);
    tick();
`ifdef HAZARD_CTRL_FWD_EN
    nop(); smp();
    chk("A3_fa", fwd_a_sel, 1);
    chk("A3_fb", fwd_b_sel, 0);
    chk("A3_stall", stall, 0);
    tick();
`else
    smp();
    chk("A3_stall", stall, 1);
    chk("A3_fa", fwd_a_sel, 0);
    tick(); smp();
    chk("A4_stall", stall, 0);
    tick(); nop(); smp();
    chk("A5_fa", fwd_a_sel, 0);
    chk("A5_fb", fwd_b_sel, 0);
    tick();
`endif
    smp();
    chk("A_cnt", stall_cnt, F ? 0 : 2);
    // lw r5 then add r6,r5,r7
    rst_seq();
    id(1'b1, 1, 0, 1'b1, 1'b0, 1'b1, 5, 1'b1); smp();
    chk("B1_stall", stall, 0);
    tick();
    id(1'b1, 5, 7, 1'b1, 1'b1, 1'b1, 6, 1'b0); smp();
    chk("B2_stall", stall, 1);
    tick(); smp();
    chk("B3_stall", stall, F ? 0 : 1);
    chk("B3_fa", fwd_a_sel, 0);
    tick();
`ifdef HAZARD_CTRL_FWD_EN
    nop(); smp();
    chk("B4_fa", fwd_a_sel, 2);
    chk("B4_fb", fwd_b_sel, 0);
    chk("B4_stall", stall, 0);
    chk("B4_cnt", stall_cnt, 1);
`else
    smp();
    chk("B4_stall", stall, 0);
    chk("B4_fa", fwd_a_sel, 0);
    chk("B4_cnt", stall_cnt, 2);
`endif
    // load to r0 then reader of r0
    rst_seq();
    id(1'b1, 1, 0, 1'b1, 1'b0, 1'b1, 0, 1'b1); smp(); tick();
    id(1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 8, 1'b0); smp();
    chk("C_stall", stall, 0);
    tick(); nop(); smp();
    chk("C_fa", fwd_a_sel, 0);
    chk("C_fb", fwd_b_sel, 0);
    chk("C_stall2", stall, 0);
    // invalid ID with matching fields
    rst_seq();
    id(1'b1, 1, 0, 1'b1, 1'b0, 1'b1, 5, 1'b1); smp(); tick();
    id(1'b0, 5, 5, 1'b1, 1'b1, 1'b1, 6, 1'b0); smp();
    chk("V_stall", stall, 0);
    // branch taken while load-use stall pending
    rst_seq();
    id(1'b1, 1, 0, 1'b1, 1'b0, 1'b1, 5, 1'b1); smp(); tick();
    id(1'b1, 5, 7, 1'b1, 1'b1, 1'b1, 6, 1'b0); br_taken = 1'b1; smp();
    chk("D_flush", flush, 1);
    chk("D_stall", stall, 0);
    tick(); br_taken = 1'b0; smp();
    chk("D_flush_low", flush, 0);
    chk("D_stall_after", stall, 0);
    chk("D_fa", fwd_a_sel, 0);
    chk("D_fb", fwd_b_sel, 0);
    tick(); nop(); smp();
    chk("D_fa_next", fwd_a_sel, 0);
    chk("D_cnt", stall_cnt, 0);
    // repeated lw r5,(r5): counter saturation and async reset mid-stall
    rst_seq();
    id(1'b1, 5, 0, 1'b1, 1'b0, 1'b1, 5, 1'b1);
    repeat (12) tick();
    smp();
    chk("E_cnt_sat", stall_cnt, 3);
    tick(); tick(); smp();
    chk("E_cnt_hold", stall_cnt, 3);
    k = 0;
    while (!stall && k < 4) begin
      @(posedge clk); @(negedge clk);
      k++;
    end
    chk("E_stall_pending", stall, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("E_rst_cnt", stall_cnt, 0);
    chk("E_rst_stall", stall, 0);
    chk("E_rst_fa", fwd_a_sel, 0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("E_post_stall", stall, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
